mod_accum_sched: RTL and testbench
==================================

Name: mod_accum_sched

Overview:
- Round-robin scheduler that shares one modulo-M accumulator datapath among N requesters.
- Each granted requester streams a job of LEN operands. The block sums them mod M and returns one result tagged with the requester ID.
- Sits between operand producers (e.g. HDC encoder lanes) and the downstream consumer of modular sums.

Parameters:
- N, 4, number of requesters (N >= 2)
- M, 100, modulus (M >= 2); DW = $clog2(M), IW = $clog2(N)
- LW, 8, width of job length field

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  N  per-requester request / operand-valid
- req_len  input  N*LW  per-requester job length; slice i = [i*LW +: LW]; sampled only at grant
- req_data  input  N*DW  per-requester operand; slice i = [i*DW +: DW]
- req_ready  output  N  operand accepted (one-hot or zero)
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_data  output  DW  modular sum, always in [0, M-1]
- res_id  output  IW  requester index that produced res_data

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - FSM=IDLE; acc=0; beat counter=0; RR pointer=0.
  - req_ready=0; res_valid=0; res_data=0; res_id=0.
  - Reset mid-job abandons the job; no partial result is emitted.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - If any req_valid bit is set, grant the first set bit searching from the RR pointer upward, wrapping.
  - On grant: gnt<=winner; cnt<=req_len[winner]; acc<=0; RR pointer<=(winner+1) mod N.
  - If req_len[winner]==0: go to DONE with acc=0. Otherwise go to ACCUM.
  - IDLE always lasts at least 1 cycle. req_ready=0 in IDLE.
- ACCUM:
  - req_ready[gnt]=1 combinationally; all other req_ready bits are 0.
  - Beat = req_valid[gnt] && req_ready[gnt].
  - Per beat: acc<=modadd(acc, req_data[gnt]); cnt<=cnt-1.
  - If req_valid[gnt] is low, stall with acc and cnt held. There is no timeout.
  - The beat with cnt==1 is the last beat; the next state is DONE.
  - req_valid from other requesters is ignored until the next IDLE.
- modadd:
  - Operand reduction: d' = (d >= M) ? d - M : d. Since 2^DW < 2M, this single subtraction is sufficient.
  - s = acc + d' computed at DW+1 bits; result = (s >= M) ? s - M : s.
  - No overflow can occur; the result is always < M.
- DONE:
  - res_valid=1; res_data=acc; res_id=gnt.
  - All three are registered and held stable while res_ready=0.
  - On res_valid && res_ready: go to IDLE next cycle and clear res_valid.
- Latency:
  - Grant cycle to first possible beat: 1 cycle.
  - Last beat to res_valid: 1 cycle (res_valid registered).
  - len=0: res_valid on the cycle after grant.
  - Minimum job occupancy = 1 (IDLE) + len + 1 (DONE).
- Simultaneous events:
  - A requester whose req_valid rises in the same cycle the FSM leaves DONE is considered in the following IDLE cycle.
  - A requester may hold req_valid across its own result; it re-competes under round-robin.
- Fairness: with all N requesting continuously, grants rotate strictly 0,1,...,N-1,0 from reset.

Test Plan:
- Req0, len=3, data 60,50,30, res_ready=1 -> req_ready[0] high for exactly 3 beats; res_data=40, res_id=0; res_valid 1 cycle after the 3rd beat.
- Req2, len=2, data 127,99 (M=100) -> 127 reduces to 27; res_data=(27+99) mod 100=26, res_id=2.
- All 4 req_valid held high, len=1, data=i+1 for requester i -> results in order id 0,1,2,3,0 with data 1,2,3,4,1; req_ready never multi-hot.
- Req1, len=0 -> no req_ready pulse; res_valid next cycle after grant, res_data=0, res_id=1.
- Req3, len=4, req_valid dropped 3 cycles after beat 2, res_ready held low 5 cycles in DONE -> acc/cnt hold during stall; res_valid/res_data/res_id stable for all 5 cycles; no req_ready while in DONE.
- rst_n pulsed low after 2 of 4 beats of req0's job -> all outputs 0 immediately; after release with req0 and req1 valid, req0 granted first (pointer back to 0); no stale result emitted.

Source files
------------

// File: rtl/mod_accum_sched.sv
// mod_accum_sched: round-robin scheduler sharing a single modulo-M accumulator
// among N requesters. A granted requester streams req_len operands; the block
// returns their sum mod M tagged with the requester index.
module mod_accum_sched #(
    parameter int N  = 4,
    parameter int M  = 100,
    parameter int LW = 8,
    parameter int DW = $clog2(M),
    parameter int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_valid,
    input  logic [N*LW-1:0] req_len,
    input  logic [N*DW-1:0] req_data,
    output logic [N-1:0]    req_ready,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [DW-1:0]   res_data,
    output logic [IW-1:0]   res_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Modulus at one bit wider than the data path so sums never wrap.
    localparam logic [DW:0] MOD = (DW+1)'(M);

    state_t          state_q, state_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic            res_valid_q, res_valid_d;

    logic [LW-1:0]   len_arr  [N];
    logic [DW-1:0]   data_arr [N];

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   win_next;

    logic [DW:0]     op_raw;
    logic [DW:0]     op_red;
    logic [DW:0]     sum_w;
    logic [DW-1:0]   modsum;
    logic            beat;

    // Unpack the flat per-requester buses into indexable arrays.
    for (genvar gi = 0; gi < N; gi++) begin : g_split
        assign len_arr[gi]  = req_len[gi*LW +: LW];
        assign data_arr[gi] = req_data[gi*DW +: DW];
    end

    // Round-robin search: first set req_valid bit at or above rr_q, wrapping.
    // Iterating from the far end lets the nearest candidate overwrite last.
    always_comb begin
        int pos;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(rr_q) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (req_valid[pos]) begin
                win_found = 1'b1;
                win_idx   = IW'(pos);
            end
        end
    end

    assign win_next = (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;

    // Modular add: fold the operand once into [0, M-1] (2^DW < 2M guarantees
    // one subtraction suffices), then add and fold the sum once more.
    assign op_raw = {1'b0, data_arr[gnt_q]};
    assign op_red = (op_raw >= MOD) ? (op_raw - MOD) : op_raw;
    assign sum_w  = {1'b0, acc_q} + op_red;
    assign modsum = (sum_w >= MOD) ? DW'(sum_w - MOD) : DW'(sum_w);

    assign beat = (state_q == ACCUM) && req_valid[gnt_q];

    // Next-state and handshake logic for the IDLE -> ACCUM -> DONE job flow.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        res_valid_d = res_valid_q;
        req_ready   = '0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_d = win_idx;
                    cnt_d = len_arr[win_idx];
                    acc_d = '0;
                    rr_d  = win_next;
                    if (len_arr[win_idx] == '0) begin
                        // Empty job: result is 0, produced right away.
                        state_d     = DONE;
                        res_valid_d = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end

            ACCUM: begin
                req_ready[gnt_q] = 1'b1;
                if (beat) begin
                    acc_d = modsum;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == LW'(1)) begin
                        state_d     = DONE;
                        res_valid_d = 1'b1;
                    end
                end
            end

            DONE: begin
                if (res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end

            default: begin
                state_d     = IDLE;
                res_valid_d = 1'b0;
            end
        endcase
    end

    // State register; reset abandons any job in flight without emitting it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rr_q        <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rr_q        <= rr_d;
            res_valid_q <= res_valid_d;
        end
    end

    // Result is the accumulator and grant registers, stable throughout DONE.
    assign res_valid = res_valid_q;
    assign res_data  = acc_q;
    assign res_id    = gnt_q;

endmodule

// File: tb/tb_mod_accum_sched.sv
// Testbench for mod_accum_sched: directed scenarios plus randomized traffic
// checked against a cycle-level job model built from the block's rules.
module tb_mod_accum_sched;

    localparam int N  = 4;
    localparam int M  = 100;
    localparam int LW = 8;
    localparam int DW = $clog2(M);
    localparam int IW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*LW-1:0] req_len = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [DW-1:0]   res_data;
    logic [IW-1:0]   res_id;

    int checks = 0;
    int errors = 0;

    // Job description shared by the scenario tasks and the traffic model.
    int job_left [N];
    int job_len  [N];
    int job_data [N][8];
    int m_ptr = 0;
    int res_ids[$];
    int res_vals[$];

    mod_accum_sched #(.N(N), .M(M), .LW(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_len   (req_len),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_jobs();
        for (int i = 0; i < N; i++) begin
            job_left[i] = 0;
            job_len[i]  = 0;
            for (int k = 0; k < 8; k++) job_data[i][k] = 0;
        end
    endtask

    // Drive all posted jobs until they complete. Each cycle the model states
    // which requester must see req_ready and whether a result is due; results
    // are the plain sum of the operands mod M.
    task automatic run_sched(input int rdy_pct, input int stall_pct, input int max_cyc);
        int phase;   // 0: waiting for grant, 1: taking operands, 2: result due
        int cur, beats, sum, cyc, idx;
        bit fin, any, found;
        logic [N-1:0] v;
        logic [N-1:0] exp_rdy;
        phase = 0; cur = 0; beats = 0; sum = 0; cyc = 0; fin = 0;
        res_ids.delete();
        res_vals.delete();
        while (!fin) begin
            any = 0;
            for (int i = 0; i < N; i++) if (job_left[i] > 0) any = 1;
            if (phase == 0 && !any) begin
                fin = 1;
            end else if (cyc >= max_cyc) begin
                checks++;
                errors++;
                $display("FAIL sched_timeout got=%0d cycles required=<%0d", cyc, max_cyc);
                fin = 1;
            end else begin
                for (int i = 0; i < N; i++) begin
                    v[i] = (job_left[i] > 0);
                    if (phase == 1 && i == cur && $urandom_range(99) < stall_pct) v[i] = 1'b0;
                    if (phase == 1 && i == cur && beats < job_len[i])
                        req_data[i*DW +: DW] = DW'(job_data[i][beats]);
                    else
                        req_data[i*DW +: DW] = DW'($urandom_range(127));
                    req_len[i*LW +: LW] = LW'(job_len[i]);
                end
                req_valid = v;
                res_ready = ($urandom_range(99) < rdy_pct);
                #1;
                exp_rdy = '0;
                if (phase == 1) exp_rdy[cur] = 1'b1;
                checks++;
                if (req_ready !== exp_rdy) begin
                    errors++;
                    $display("FAIL sched_req_ready got=%b required=%b", req_ready, exp_rdy);
                end
                checks++;
                if (res_valid !== (phase == 2)) begin
                    errors++;
                    $display("FAIL sched_res_valid got=%b required=%b", res_valid, (phase == 2));
                end
                if (phase == 2) begin
                    checks++;
                    if (res_data !== DW'(sum % M)) begin
                        errors++;
                        $display("FAIL sched_res_data got=%0d required=%0d", res_data, sum % M);
                    end
                    checks++;
                    if (res_id !== IW'(cur)) begin
                        errors++;
                        $display("FAIL sched_res_id got=%0d required=%0d", res_id, cur);
                    end
                end
                // Advance the model to the next cycle.
                case (phase)
                    0: begin
                        found = 0;
                        for (int k = 0; k < N; k++) begin
                            idx = (m_ptr + k) % N;
                            if (!found && v[idx]) begin
                                found = 1;
                                cur = idx;
                            end
                        end
                        if (found) begin
                            m_ptr = (cur + 1) % N;
                            beats = 0;
                            sum = 0;
                            phase = (job_len[cur] == 0) ? 2 : 1;
                        end
                    end
                    1: begin
                        if (v[cur]) begin
                            sum += job_data[cur][beats];
                            beats++;
                            if (beats == job_len[cur]) phase = 2;
                        end
                    end
                    default: begin
                        if (res_ready) begin
                            $display("txn id=%0d len=%0d data=%0d", cur, job_len[cur], sum % M);
                            res_ids.push_back(cur);
                            res_vals.push_back(sum % M);
                            job_left[cur]--;
                            phase = 0;
                        end
                    end
                endcase
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        req_valid = '0;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = '0;
        res_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got=%b required=0", req_ready); end
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b required=0", res_valid); end
        checks++;
        if (res_data !== '0) begin errors++; $display("FAIL reset_res_data got=%0d required=0", res_data); end
        checks++;
        if (res_id !== '0) begin errors++; $display("FAIL reset_res_id got=%0d required=0", res_id); end
        rst_n = 1'b1;
        m_ptr = 0;
        tick();
    endtask

    task automatic test_fairness();
        int exp_ids[5]  = '{0, 1, 2, 3, 0};
        int exp_vals[5] = '{1, 2, 3, 4, 1};
        clear_jobs();
        for (int i = 0; i < N; i++) begin
            job_left[i] = (i == 0) ? 2 : 1;
            job_len[i] = 1;
            job_data[i][0] = i + 1;
        end
        run_sched(100, 0, 200);
        checks++;
        if (res_ids.size() != 5) begin
            errors++;
            $display("FAIL fair_count got=%0d required=5", res_ids.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (res_ids[k] != exp_ids[k] || res_vals[k] != exp_vals[k]) begin
                    errors++;
                    $display("FAIL fair_order[%0d] got=id%0d/%0d required=id%0d/%0d",
                             k, res_ids[k], res_vals[k], exp_ids[k], exp_vals[k]);
                end
            end
        end
    endtask

    task automatic test_basic();
        clear_jobs();
        job_left[0] = 1;
        job_len[0] = 3;
        job_data[0][0] = 60; job_data[0][1] = 50; job_data[0][2] = 30;
        run_sched(100, 0, 100);
        checks++;
        if (res_vals.size() != 1 || res_vals[0] != 40 || res_ids[0] != 0) begin
            errors++;
            $display("FAIL basic_result got=n%0d required=id0/40", res_vals.size());
        end
    endtask

    task automatic test_reduce();
        clear_jobs();
        job_left[2] = 1;
        job_len[2] = 2;
        job_data[2][0] = 127; job_data[2][1] = 99;
        run_sched(100, 0, 100);
        checks++;
        if (res_vals.size() != 1 || res_vals[0] != 26 || res_ids[0] != 2) begin
            errors++;
            $display("FAIL reduce_result got=n%0d required=id2/26", res_vals.size());
        end
    endtask

    task automatic test_len_zero();
        clear_jobs();
        job_left[1] = 1;
        job_len[1] = 0;
        run_sched(100, 0, 100);
        checks++;
        if (res_vals.size() != 1 || res_vals[0] != 0 || res_ids[0] != 1) begin
            errors++;
            $display("FAIL len_zero_result got=n%0d required=id1/0", res_vals.size());
        end
    endtask

    // Requester 3, four operands, valid dropped for three cycles after the
    // second beat, then the consumer holds off for five cycles.
    task automatic test_stall();
        int d[4];
        int exp;
        exp = 0;
        for (int k = 0; k < 4; k++) begin
            d[k] = $urandom_range(127);
            exp += d[k];
        end
        exp = exp % M;
        req_len[3*LW +: LW] = LW'(4);
        req_data[3*DW +: DW] = DW'(d[0]);
        req_valid = 4'b1000;
        res_ready = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                req_valid = 4'b0000;
                for (int s = 0; s < 3; s++) begin
                    checks++;
                    if (req_ready !== 4'b1000 || res_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_hold got=%b/%b required=1000/0", req_ready, res_valid);
                    end
                    tick();
                end
                req_valid = 4'b1000;
            end
            req_data[3*DW +: DW] = DW'(d[k]);
            checks++;
            if (req_ready !== 4'b1000 || res_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_beat%0d got=%b/%b required=1000/0", k, req_ready, res_valid);
            end
            tick();
        end
        req_valid = '0;
        for (int s = 0; s < 5; s++) begin
            checks++;
            if (res_valid !== 1'b1 || res_data !== DW'(exp) || res_id !== IW'(3) || req_ready !== '0) begin
                errors++;
                $display("FAIL stall_done%0d got=v%b d%0d id%0d r%b required=v1 d%0d id3 r0",
                         s, res_valid, res_data, res_id, req_ready, exp);
            end
            tick();
        end
        res_ready = 1'b1;
        checks++;
        if (res_valid !== 1'b1) begin errors++; $display("FAIL stall_handshake got=%b required=1", res_valid); end
        $display("txn id=3 len=4 data=%0d", exp);
        tick();
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL stall_after got=%b/%b required=0/0", res_valid, req_ready);
        end
        m_ptr = 0;
    endtask

    task automatic test_random();
        int total;
        bit any;
        for (int r = 0; r < 8; r++) begin
            clear_jobs();
            total = 0;
            any = 0;
            for (int i = 0; i < N; i++) begin
                job_left[i] = $urandom_range(2);
                job_len[i] = $urandom_range(6);
                for (int k = 0; k < 8; k++) job_data[i][k] = $urandom_range(127);
                if (job_left[i] > 0) any = 1;
            end
            if (!any) job_left[$urandom_range(N - 1)] = 1;
            for (int i = 0; i < N; i++) total += job_left[i];
            run_sched(60, 25, 3000);
            checks++;
            if (res_vals.size() != total) begin
                errors++;
                $display("FAIL random_count[%0d] got=%0d required=%0d", r, res_vals.size(), total);
            end
        end
    endtask

    task automatic test_reset_mid_job();
        req_len[0*LW +: LW] = LW'(4);
        req_data[0*DW +: DW] = DW'(11);
        req_valid = 4'b0001;
        res_ready = 1'b1;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== '0 || res_valid !== 1'b0 || res_data !== '0 || res_id !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got=r%b v%b d%0d id%0d required=all 0",
                     req_ready, res_valid, res_data, res_id);
        end
        req_valid = 4'b0011;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== '0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_held got=r%b v%b required=0/0", req_ready, res_valid);
        end
        rst_n = 1'b1;
        m_ptr = 0;
        clear_jobs();
        job_left[0] = 1; job_len[0] = 3;
        job_left[1] = 1; job_len[1] = 2;
        for (int k = 0; k < 8; k++) begin
            job_data[0][k] = $urandom_range(127);
            job_data[1][k] = $urandom_range(127);
        end
        run_sched(100, 0, 100);
        checks++;
        if (res_ids.size() != 2 || res_ids[0] != 0) begin
            errors++;
            $display("FAIL midreset_first_grant got=n%0d required=id0 first", res_ids.size());
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_basic();
        test_reduce();
        test_len_zero();
        test_stall();
        test_random();
        test_reset_mid_job();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
